// File: rtl/name_entry_pkg.sv
// Shared header for the high-score path (name_entry and the scoreboard).
// Holds letter/score sizing and the derived tag width.
//   ALPHABET_SIZE : bits per letter code
//   SCORE_SIZE    : bits per score
//   LETTER_COUNT  : legal letter codes are 0..LETTER_COUNT-1, 0 = 'A'
package name_entry_pkg;
    localparam int ALPHABET_SIZE = 5;
    localparam int SCORE_SIZE    = 16;
    localparam int LETTER_COUNT  = 26;
    localparam int TAG_LETTERS   = 3;
    localparam int STRING_W      = TAG_LETTERS * ALPHABET_SIZE;

    typedef logic [ALPHABET_SIZE-1:0] letter_t;
    typedef logic [SCORE_SIZE-1:0]    score_t;
    typedef logic [STRING_W-1:0]      tag_t;
endpackage

// File: rtl/name_entry_if.sv
// Scoreboard insert port. name_entry is the only master.
// Handshake: `insert` is a one-cycle write strobe with no back-pressure;
// `new_score`/`new_string` are valid whenever `insert` is high and hold
// their value until the next strobe.
//   insert     : write strobe
//   new_score  : score to insert
//   new_string : tag {letter0, letter1, letter2}, letter0 in the MSBs
interface name_entry_if;
    import name_entry_pkg::*;

    logic   insert;
    score_t new_score;
    tag_t   new_string;

    modport master (output insert, output new_score, output new_string);
    modport slave  (input  insert, input  new_score, input  new_string);
endinterface

// File: rtl/name_entry_letter_wheel.sv
// letter_wheel: one tag letter. Steps up/down with wrap at LETTER_COUNT,
// clears on `clear`. Up wins over down when both are asserted.
//   clk, rst : clock, synchronous active-high reset
//   clear    : load zero (overrides everything else)
//   en       : this wheel is the one under the cursor
//   up, down : step requests, acted on only when en
//   letter   : current registered letter code
module letter_wheel
    import name_entry_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    clear,
    input  logic    en,
    input  logic    up,
    input  logic    down,
    output letter_t letter
);
    letter_t letter_q, letter_d;

    always_comb begin
        letter_d = letter_q;
        if (clear) begin
            letter_d = '0;
        end else if (en && up) begin
            letter_d = (letter_q == letter_t'(LETTER_COUNT - 1)) ? '0 : letter_q + 1'b1;
        end else if (en && down) begin
            letter_d = (letter_q == '0) ? letter_t'(LETTER_COUNT - 1) : letter_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) letter_q <= '0;
        else     letter_q <= letter_d;
    end

    assign letter = letter_q;
endmodule

// File: rtl/name_entry.sv
// name_entry: after game over, checks whether the final score beats the
// scoreboard's 5th place; if so lets the player spell a 3-letter tag and
// then writes score+tag to the scoreboard with a single insert strobe.
//   clk, rst                 : clock, synchronous active-high reset
//   start                    : one-cycle game-over pulse (ignored while busy)
//   final_score, fifth_score : sampled on start
//   btn_up/down/confirm/back : one-cycle button pulses, used only in ENTRY
//   ins                      : scoreboard insert port (master)
//   cur_string, cursor       : live tag and edit position for the display
//   busy, qualified, done    : status; done pulses on commit or reject
//   state_dbg                : current FSM state (IDLE=0 ENTRY=1 COMMIT=2 REJECT=3)
module name_entry
    import name_entry_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  score_t       final_score,
    input  score_t       fifth_score,
    input  logic         btn_up,
    input  logic         btn_down,
    input  logic         btn_confirm,
    input  logic         btn_back,
    name_entry_if.master ins,
    output tag_t         cur_string,
    output logic [1:0]   cursor,
    output logic         busy,
    output logic         qualified,
    output logic         done,
    output logic [1:0]   state_dbg
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ENTRY  = 2'd1,
        S_COMMIT = 2'd2,
        S_REJECT = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] cursor_q, cursor_d;
    score_t     score_q, score_d;
    score_t     new_score_q, new_score_d;
    tag_t       new_string_q, new_string_d;
    logic       qualified_q, qualified_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       insert_q, insert_d;

    logic       clear_tag;
    logic       in_entry;
    logic       up_act, down_act;
    letter_t    letters [TAG_LETTERS];

    // One button per cycle: confirm > back > up > down.
    assign up_act   = btn_up   & ~btn_confirm & ~btn_back;
    assign down_act = btn_down & ~btn_up & ~btn_confirm & ~btn_back;

    always_comb begin
        state_d     = state_q;
        cursor_d    = cursor_q;
        score_d     = score_q;
        qualified_d = qualified_q;
        clear_tag   = 1'b0;
        in_entry    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    score_d = final_score;
                    // Strict compare: a tie does not displace 5th place.
                    if (final_score > fifth_score) begin
                        qualified_d = 1'b1;
                        cursor_d    = 2'd0;
                        clear_tag   = 1'b1;
                        state_d     = S_ENTRY;
                    end else begin
                        qualified_d = 1'b0;
                        state_d     = S_REJECT;
                    end
                end
            end
            S_ENTRY: begin
                in_entry = 1'b1;
                if (btn_confirm) begin
                    if (cursor_q == 2'd2) state_d  = S_COMMIT;
                    else                  cursor_d = cursor_q + 2'd1;
                end else if (btn_back) begin
                    if (cursor_q != 2'd0) cursor_d = cursor_q - 2'd1;
                end
            end
            S_COMMIT: state_d = S_IDLE;
            S_REJECT: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase

        // Status flags are decoded from the next state so they are flops.
        busy_d   = (state_d != S_IDLE);
        insert_d = (state_d == S_COMMIT);
        done_d   = (state_d == S_COMMIT) || (state_d == S_REJECT);

        // Insert payload is captured only on the way into COMMIT; letters
        // cannot change on the final confirm, so cur_string is already final.
        new_score_d  = new_score_q;
        new_string_d = new_string_q;
        if (state_q == S_ENTRY && state_d == S_COMMIT) begin
            new_score_d  = score_q;
            new_string_d = cur_string;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cursor_q     <= 2'd0;
            score_q      <= '0;
            new_score_q  <= '0;
            new_string_q <= '0;
            qualified_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            insert_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cursor_q     <= cursor_d;
            score_q      <= score_d;
            new_score_q  <= new_score_d;
            new_string_q <= new_string_d;
            qualified_q  <= qualified_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            insert_q     <= insert_d;
        end
    end

    for (genvar i = 0; i < TAG_LETTERS; i++) begin : g_wheel
        letter_wheel u_wheel (
            .clk    (clk),
            .rst    (rst),
            .clear  (clear_tag),
            .en     (in_entry && (cursor_q == 2'(i))),
            .up     (up_act),
            .down   (down_act),
            .letter (letters[i])
        );
    end

    assign cur_string     = {letters[0], letters[1], letters[2]};
    assign cursor         = cursor_q;
    assign busy           = busy_q;
    assign qualified      = qualified_q;
    assign done           = done_q;
    assign state_dbg      = state_q;
    assign ins.insert     = insert_q;
    assign ins.new_score  = new_score_q;
    assign ins.new_string = new_string_q;
endmodule

// File: tb/tb_name_entry.sv
module tb_name_entry;
    import name_entry_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       start = 1'b0;
    score_t     final_score = '0;
    score_t     fifth_score = '0;
    logic       btn_up = 1'b0, btn_down = 1'b0, btn_confirm = 1'b0, btn_back = 1'b0;
    tag_t       cur_string;
    logic [1:0] cursor;
    logic       busy, qualified, done;
    logic [1:0] state_dbg;

    name_entry_if ins_if ();

    name_entry dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .final_score (final_score),
        .fifth_score (fifth_score),
        .btn_up      (btn_up),
        .btn_down    (btn_down),
        .btn_confirm (btn_confirm),
        .btn_back    (btn_back),
        .ins         (ins_if.master),
        .cur_string  (cur_string),
        .cursor      (cursor),
        .busy        (busy),
        .qualified   (qualified),
        .done        (done),
        .state_dbg   (state_dbg)
    );

    int checks = 0;
    int passes = 0;
    int fails  = 0;
    int insert_cnt = 0;

    // Count insert strobes; the value read at a posedge is the one held
    // during the cycle that just ended.
    always @(posedge clk) if (ins_if.insert === 1'b1) insert_cnt++;

    initial begin
        #200000;
        $display("FAIL watchdog: no finish, observed time %0t, required < 200000", $time);
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    function automatic logic [31:0] tag3(input int l0, input int l1, input int l2);
        return 32'((l0 << 10) | (l1 << 5) | l2);
    endfunction

    // ---------------- driver tasks ----------------
    // Inputs change at negedge; after each task returns we sit at a negedge
    // with the effect of one posedge visible.
    task automatic cycle();
        @(negedge clk);
    endtask

    task automatic press(input logic u, input logic d, input logic c, input logic b);
        btn_up = u; btn_down = d; btn_confirm = c; btn_back = b;
        @(negedge clk);
        btn_up = 0; btn_down = 0; btn_confirm = 0; btn_back = 0;
    endtask

    task automatic do_start(input int fifth, input int fin);
        fifth_score = score_t'(fifth);
        final_score = score_t'(fin);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".insert"},     32'(ins_if.insert), 0);
        check({tag, ".new_score"},  32'(ins_if.new_score), 0);
        check({tag, ".new_string"}, 32'(ins_if.new_string), 0);
        check({tag, ".cur_string"}, 32'(cur_string), 0);
        check({tag, ".cursor"},     32'(cursor), 0);
        check({tag, ".busy"},       32'(busy), 0);
        check({tag, ".qualified"},  32'(qualified), 0);
        check({tag, ".done"},       32'(done), 0);
        check({tag, ".state"},      32'(state_dbg), 0);
    endtask

    // Final confirm at cursor 2: checks the commit cycle and the return to idle.
    task automatic commit_and_check(input string tag, input int score, input logic [31:0] str, input int cnt_after);
        press(0, 0, 1, 0);
        check({tag, ".insert"},     32'(ins_if.insert), 1);
        check({tag, ".done"},       32'(done), 1);
        check({tag, ".busy_c"},     32'(busy), 1);
        check({tag, ".new_score"},  32'(ins_if.new_score), 32'(score));
        check({tag, ".new_string"}, 32'(ins_if.new_string), str);
        cycle();
        check({tag, ".insert_off"}, 32'(ins_if.insert), 0);
        check({tag, ".done_off"},   32'(done), 0);
        check({tag, ".busy_off"},   32'(busy), 0);
        check({tag, ".hold_score"}, 32'(ins_if.new_score), 32'(score));
        check({tag, ".hold_str"},   32'(ins_if.new_string), str);
        check({tag, ".insert_cnt"}, 32'(insert_cnt), 32'(cnt_after));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst = 1'b1;
        cycle(); cycle();
        rst = 1'b0;
        check_all_zero("reset");

        // Non-qualifying: tie does not displace.
        do_start(14, 14);
        check("rej.busy", 32'(busy), 1);
        check("rej.qualified", 32'(qualified), 0);
        check("rej.done", 32'(done), 1);
        check("rej.insert", 32'(ins_if.insert), 0);
        check("rej.state", 32'(state_dbg), 3);
        cycle();
        check("rej.busy_off", 32'(busy), 0);
        check("rej.done_off", 32'(done), 0);
        cycle();
        check("rej.insert_cnt", 32'(insert_cnt), 0);

        // Basic entry: up x3, confirm x2, up x3, confirm -> {3,0,3}.
        do_start(0, 25);
        check("basic.busy", 32'(busy), 1);
        check("basic.qualified", 32'(qualified), 1);
        check("basic.done", 32'(done), 0);
        check("basic.cursor0", 32'(cursor), 0);
        check("basic.str0", 32'(cur_string), 0);
        for (int i = 0; i < 3; i++) press(1, 0, 0, 0);
        check("basic.str_l0", 32'(cur_string), tag3(3, 0, 0));
        press(0, 0, 1, 0);
        check("basic.cursor1", 32'(cursor), 1);
        press(0, 0, 1, 0);
        check("basic.cursor2", 32'(cursor), 2);
        for (int i = 0; i < 3; i++) press(1, 0, 0, 0);
        check("basic.str_l2", 32'(cur_string), tag3(3, 0, 3));
        commit_and_check("basic", 25, tag3(3, 0, 3), 1);

        // Wrap, back no-op at 0, back edits letter1.
        do_start(0, 10);
        press(0, 1, 0, 0);
        check("wrap.down", 32'(cur_string), tag3(25, 0, 0));
        press(1, 0, 0, 0);
        check("wrap.up", 32'(cur_string), tag3(0, 0, 0));
        press(0, 0, 0, 1);
        check("wrap.back0", 32'(cursor), 0);
        check("wrap.back0_str", 32'(cur_string), 0);
        press(0, 0, 1, 0);
        press(0, 0, 1, 0);
        press(0, 0, 0, 1);
        check("wrap.back2", 32'(cursor), 1);
        press(1, 0, 0, 0);
        check("wrap.l1", 32'(cur_string), tag3(0, 1, 0));
        press(0, 0, 1, 0);
        commit_and_check("wrap", 10, tag3(0, 1, 0), 2);

        // Priority: confirm beats up; up beats down; back beats up.
        do_start(0, 7);
        press(1, 0, 1, 0);
        check("prio.cu_cursor", 32'(cursor), 1);
        check("prio.cu_str", 32'(cur_string), 0);
        press(1, 1, 0, 0);
        check("prio.ud_str", 32'(cur_string), tag3(0, 1, 0));
        press(1, 0, 0, 1);
        check("prio.bu_cursor", 32'(cursor), 0);
        check("prio.bu_str", 32'(cur_string), tag3(0, 1, 0));
        press(0, 0, 1, 0);
        press(0, 0, 1, 0);
        commit_and_check("prio", 7, tag3(0, 1, 0), 3);

        // Busy lockout and reset mid-entry.
        do_start(0, 100);
        press(1, 0, 0, 0);
        press(0, 0, 1, 0);
        press(1, 0, 0, 0);
        check("lock.str", 32'(cur_string), tag3(1, 1, 0));
        do_start(0, 200);
        check("lock.busy", 32'(busy), 1);
        check("lock.qualified", 32'(qualified), 1);
        check("lock.cursor", 32'(cursor), 1);
        check("lock.str_kept", 32'(cur_string), tag3(1, 1, 0));
        check("lock.state", 32'(state_dbg), 1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check_all_zero("midrst");
        cycle();
        check("midrst.insert_cnt", 32'(insert_cnt), 3);

        // Fresh session after reset commits normally.
        do_start(0, 50);
        check("post.qualified", 32'(qualified), 1);
        press(0, 0, 1, 0);
        press(0, 0, 1, 0);
        commit_and_check("post", 50, tag3(0, 0, 0), 4);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
